// File: rtl/rf_wd_pipe.sv
// MEM/WB pipeline register: selects and aligns write-back data, qualifies the
// register-file write enable, flags illegal/misaligned ops, and reports forwarding hits.
module rf_wd_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PC_INC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [2:0]      sel,
  input  logic [2:0]      ld_type,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] sext,
  input  logic [XLEN-1:0] rdo,
  input  logic            we_in,
  input  logic [4:0]      rd_in,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_wd,
  output logic            fault,
  output logic            fault_sticky,
  output logic            fwd1,
  output logic            fwd2
);

  localparam logic [2:0] SEL_ALU = 3'd0;
  localparam logic [2:0] SEL_NPC = 3'd1;
  localparam logic [2:0] SEL_SXT = 3'd2;
  localparam logic [2:0] SEL_RDO = 3'd3;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  localparam logic [XLEN-1:0] PC_INC_X = XLEN'(PC_INC);

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_word;
  logic [XLEN-1:0] ld_data;
  logic            ld_fault;
  logic [XLEN-1:0] mux_data;
  logic            mux_fault;
  logic [XLEN-1:0] next_wd;
  logic            next_fault;
  logic            next_we;

  // Lane selection is little-endian: byte lane = addr_lo, halfword lane = addr_lo[1].
  always_comb begin
    ld_word  = rdo[31:0];
    ld_half  = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    ld_byte  = ld_word[8*addr_lo +: 8];
    ld_data  = '0;
    ld_fault = 1'b0;
    unique case (ld_type)
      LD_B:    ld_data = XLEN'($signed(ld_byte));
      LD_BU:   ld_data = XLEN'(ld_byte);
      LD_H: begin
        ld_data  = XLEN'($signed(ld_half));
        ld_fault = addr_lo[0];
      end
      LD_HU: begin
        ld_data  = XLEN'(ld_half);
        ld_fault = addr_lo[0];
      end
      LD_W: begin
        ld_data  = XLEN'($signed(ld_word));
        ld_fault = (addr_lo != 2'b00);
      end
      default: ld_fault = 1'b1;
    endcase
  end

  always_comb begin
    mux_data  = '0;
    mux_fault = 1'b0;
    unique case (sel)
      SEL_ALU: mux_data = alu;
      SEL_NPC: mux_data = pc + PC_INC_X;
      SEL_SXT: mux_data = sext;
      SEL_RDO: begin
        mux_data  = ld_data;
        mux_fault = ld_fault;
      end
      default: mux_fault = 1'b1;
    endcase
  end

  // A faulting op never writes and carries zero data; faults on idle slots are ignored.
  assign next_fault = in_valid & mux_fault;
  assign next_wd    = mux_fault ? '0 : mux_data;
  assign next_we    = we_in & in_valid & ~mux_fault & (rd_in != 5'd0);

  // Priority rst > flush > stall > capture; the stage accepts whenever stall is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= '0;
      wb_wd        <= '0;
      fault        <= 1'b0;
      fault_sticky <= 1'b0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      fault    <= 1'b0;
    end else if (stall) begin
      fault <= 1'b0;
    end else begin
      wb_valid <= in_valid;
      wb_we    <= next_we;
      wb_rd    <= rd_in;
      wb_wd    <= next_wd;
      fault    <= next_fault;
      if (next_fault) fault_sticky <= 1'b1;
    end
  end

  assign fwd1 = wb_valid & wb_we & (wb_rd != 5'd0) & (wb_rd == rs1);
  assign fwd2 = wb_valid & wb_we & (wb_rd != 5'd0) & (wb_rd == rs2);

endmodule

// File: tb/tb_rf_wd_pipe.sv
// Directed bench for rf_wd_pipe (XLEN=32): hand-computed write-back, fault,
// stall/flush and forwarding expectations.
module tb_rf_wd_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush;
  logic [2:0]  sel, ld_type;
  logic [1:0]  addr_lo;
  logic [31:0] alu, pc, sext, rdo;
  logic        we_in;
  logic [4:0]  rd_in, rs1, rs2;
  logic        wb_valid, wb_we, fault, fault_sticky, fwd1, fwd2;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;

  int n_cmp = 0;
  int n_err = 0;

  rf_wd_pipe #(.XLEN(32), .PC_INC(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .sel(sel), .ld_type(ld_type), .addr_lo(addr_lo),
    .alu(alu), .pc(pc), .sext(sext), .rdo(rdo),
    .we_in(we_in), .rd_in(rd_in), .rs1(rs1), .rs2(rs2),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .fault(fault), .fault_sticky(fault_sticky), .fwd1(fwd1), .fwd2(fwd2)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drivers: inputs change #1 after a rising edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rst = 0; in_valid = 0; stall = 0; flush = 0;
    sel = 0; ld_type = 0; addr_lo = 0;
    alu = 0; pc = 0; sext = 0; rdo = 0;
    we_in = 0; rd_in = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic issue(input logic [2:0] s, input logic [2:0] lt, input logic [1:0] al,
                       input logic [4:0] rd, input logic we);
    in_valid = 1; sel = s; ld_type = lt; addr_lo = al; rd_in = rd; we_in = we;
    tick();
  endtask

  initial begin
    drive_idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    check("rst_valid", 32'(wb_valid), 32'd0);
    check("rst_we", 32'(wb_we), 32'd0);
    check("rst_rd", 32'(wb_rd), 32'd0);
    check("rst_wd", wb_wd, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_sticky", 32'(fault_sticky), 32'd0);

    alu = 32'h1234_5678;
    issue(3'd0, 3'b000, 2'd0, 5'd5, 1'b1);
    check("alu_wd", wb_wd, 32'h1234_5678);
    check("alu_we", 32'(wb_we), 32'd1);
    check("alu_rd", 32'(wb_rd), 32'd5);
    check("alu_valid", 32'(wb_valid), 32'd1);
    check("alu_fault", 32'(fault), 32'd0);

    pc = 32'hFFFF_FFFC;
    issue(3'd1, 3'b000, 2'd0, 5'd6, 1'b1);
    check("npc_wrap", wb_wd, 32'h0000_0000);
    pc = 32'h0000_1000;
    issue(3'd1, 3'b000, 2'd0, 5'd6, 1'b1);
    check("npc", wb_wd, 32'h0000_1004);
    sext = 32'hFFFF_F800;
    issue(3'd2, 3'b000, 2'd0, 5'd6, 1'b1);
    check("sext", wb_wd, 32'hFFFF_F800);

    rdo = 32'h80FF_7F01;
    issue(3'd3, 3'b000, 2'd2, 5'd8, 1'b1);
    check("lb_a2", wb_wd, 32'hFFFF_FFFF);
    issue(3'd3, 3'b100, 2'd1, 5'd8, 1'b1);
    check("lbu_a1", wb_wd, 32'h0000_007F);
    issue(3'd3, 3'b000, 2'd3, 5'd8, 1'b1);
    check("lb_a3", wb_wd, 32'hFFFF_FF80);
    issue(3'd3, 3'b001, 2'd2, 5'd8, 1'b1);
    check("lh_a2", wb_wd, 32'hFFFF_80FF);
    issue(3'd3, 3'b101, 2'd0, 5'd8, 1'b1);
    check("lhu_a0", wb_wd, 32'h0000_7F01);
    issue(3'd3, 3'b001, 2'd0, 5'd8, 1'b1);
    check("lh_a0", wb_wd, 32'h0000_7F01);
    issue(3'd3, 3'b010, 2'd0, 5'd8, 1'b1);
    check("lw_a0", wb_wd, 32'h80FF_7F01);
    check("lw_fault", 32'(fault), 32'd0);

    // Misaligned LW
    issue(3'd3, 3'b010, 2'd1, 5'd8, 1'b1);
    check("lw_mis_wd", wb_wd, 32'd0);
    check("lw_mis_we", 32'(wb_we), 32'd0);
    check("lw_mis_fault", 32'(fault), 32'd1);
    check("lw_mis_sticky", 32'(fault_sticky), 32'd1);
    alu = 32'h0000_0011;
    issue(3'd0, 3'b000, 2'd0, 5'd5, 1'b1);
    check("after_fault_pulse", 32'(fault), 32'd0);
    check("after_fault_sticky", 32'(fault_sticky), 32'd1);

    issue(3'd5, 3'b000, 2'd0, 5'd5, 1'b1);
    check("sel5_wd", wb_wd, 32'd0);
    check("sel5_we", 32'(wb_we), 32'd0);
    check("sel5_fault", 32'(fault), 32'd1);
    issue(3'd3, 3'b101, 2'd1, 5'd5, 1'b1);
    check("lhu_mis_fault", 32'(fault), 32'd1);
    issue(3'd3, 3'b011, 2'd0, 5'd5, 1'b1);
    check("ldtype3_fault", 32'(fault), 32'd1);

    // Stall right after a fault: the pulse must not repeat
    stall = 1;
    tick();
    check("stall_no_refault", 32'(fault), 32'd0);
    stall = 0;

    alu = 32'hAAAA_5555;
    issue(3'd0, 3'b000, 2'd0, 5'd9, 1'b1);
    stall = 1; alu = 32'h0BAD_0BAD; rd_in = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_wd", wb_wd, 32'hAAAA_5555);
      check("stall_rd", 32'(wb_rd), 32'd9);
      check("stall_we", 32'(wb_we), 32'd1);
    end
    flush = 1;
    tick();
    check("flush_valid", 32'(wb_valid), 32'd0);
    check("flush_we", 32'(wb_we), 32'd0);
    check("flush_wd_hold", wb_wd, 32'hAAAA_5555);
    check("flush_rd_hold", 32'(wb_rd), 32'd9);
    flush = 0; stall = 0;

    // Forwarding
    alu = 32'h0000_0077;
    issue(3'd0, 3'b000, 2'd0, 5'd7, 1'b1);
    rs1 = 5'd7; rs2 = 5'd0;
    #1;
    check("fwd1_hit", 32'(fwd1), 32'd1);
    check("fwd2_miss", 32'(fwd2), 32'd0);
    rs1 = 5'd4; rs2 = 5'd7;
    #1;
    check("fwd1_miss", 32'(fwd1), 32'd0);
    check("fwd2_hit", 32'(fwd2), 32'd1);

    issue(3'd0, 3'b000, 2'd0, 5'd0, 1'b1);
    rs1 = 5'd0; rs2 = 5'd0;
    #1;
    check("x0_we", 32'(wb_we), 32'd0);
    check("x0_valid", 32'(wb_valid), 32'd1);
    check("x0_fwd1", 32'(fwd1), 32'd0);
    check("x0_fwd2", 32'(fwd2), 32'd0);

    issue(3'd0, 3'b000, 2'd0, 5'd7, 1'b0);
    rs1 = 5'd7;
    #1;
    check("nowe_we", 32'(wb_we), 32'd0);
    check("nowe_fwd1", 32'(fwd1), 32'd0);

    in_valid = 0; sel = 3'd0; we_in = 1; rd_in = 5'd7;
    tick();
    check("idle_valid", 32'(wb_valid), 32'd0);
    check("idle_we", 32'(wb_we), 32'd0);

    // Reset while stalled and flushing
    issue(3'd0, 3'b000, 2'd0, 5'd12, 1'b1);
    check("pre_rst_sticky", 32'(fault_sticky), 32'd1);
    rst = 1; stall = 1; flush = 1;
    tick();
    check("rst2_valid", 32'(wb_valid), 32'd0);
    check("rst2_rd", 32'(wb_rd), 32'd0);
    check("rst2_wd", wb_wd, 32'd0);
    check("rst2_sticky", 32'(fault_sticky), 32'd0);
    drive_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_wd_pipe.md
# rf_wd_pipe

Registered, parametrised register-file write-back stage for the pipelined core. It replaces the single-cycle combinational write-data select with a MEM/WB pipeline register. It adds load-data alignment and sign/zero extension, stall/flush control, misalignment and illegal-select detection, and a forwarding-hit compare for the decode stage. It sits between the data-memory read port and the register file write port.

## Interface
- XLEN, 32: datapath width; must be 32 or 64. Loads narrower than XLEN are extended to XLEN.
- PC_INC, 4: increment added to `pc` for the NPC source.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  an instruction is presented this cycle.
- stall  in  1  hold the stage register.
- flush  in  1  kill the captured instruction.
- sel  in  3  source select: 0 ALU, 1 NPC, 2 SEXT, 3 RDO (load); 4–7 illegal.
- ld_type  in  3  RISC-V load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes illegal when sel=3.
- addr_lo  in  2  byte offset of the load address.
- alu, pc, sext, rdo  in  XLEN each  ALU result, instruction PC, immediate, raw memory word.
- we_in  in  1  instruction writes rd.
- rd_in  in  5  destination register.
- rs1, rs2  in  5 each  decode-stage source registers for the forwarding compare.
- wb_valid  out  1  registered valid.
- wb_we  out  1  registered, qualified write enable.
- wb_rd  out  5  registered destination.
- wb_wd  out  XLEN  registered write data.
- fault  out  1  one-cycle pulse, aligned with wb_valid, marking an illegal sel/ld_type or a misaligned load.
- fault_sticky  out  1  set by any fault; cleared only by rst.
- fwd1, fwd2  out  1 each  combinational hit: wb_valid & wb_we & (wb_rd != 0) & (wb_rd == rs1 / rs2).

## Operation
**Next-data mux (combinational):**
- sel=0 → alu; sel=1 → pc + PC_INC (mod 2^XLEN); sel=2 → sext.
- sel=3 → load extract from rdo:
  - byte lane = addr_lo, halfword lane = addr_lo[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW takes rdo[31:0]; when XLEN=64 it is sign-extended.

**Fault conditions** (each → next wb_wd = 0, next wb_we = 0, fault = 1 when registered):
- sel ≥ 4.
- sel=3 with an illegal ld_type.
- sel=3, LH/LHU with addr_lo[0]=1.
- sel=3, LW with addr_lo ≠ 0.

**Write-enable qualification:** wb_we = we_in & in_valid & ~fault & (rd_in ≠ 0). A write to x0 is never asserted, but wb_valid still reflects in_valid.

**Register update priority:**
1. rst: clear all outputs.
2. flush: wb_valid=0, wb_we=0, fault=0; wb_wd and wb_rd hold.
3. stall: all registers hold. The fault pulse does not repeat; fault is low while stalled.
4. Otherwise: capture the new values.

**fault_sticky:** sets on the same edge that sets fault; cleared only by rst.

## Timing
- Latency: 1 cycle from inputs to wb_*.
- fwd1/fwd2 are combinational from registered state plus rs1/rs2, with zero added latency.
- Reset values: wb_valid=0, wb_we=0, wb_rd=0, wb_wd=0, fault=0, fault_sticky=0.
- Reset mid-stall or mid-flush: rst wins; outputs are zero on the next edge.
- flush and stall together: flush wins; the bubble is inserted.
- in_valid=0 while not stalled: wb_valid=0 and wb_we=0 next cycle; wb_wd takes the mux value and is don't-care.
- Consecutive writes to the same rd: each is presented for exactly one non-stalled cycle.
- No internal throttling: the stage always accepts when stall=0.

## Test plan
- Reset, then sel=0, alu=0x1234_5678, rd_in=5, we_in=1, in_valid=1 → next cycle wb_wd=0x12345678, wb_we=1, wb_rd=5, fault=0.
- sel=1, pc=0xFFFF_FFFC (XLEN=32) → wb_wd=0x0000_0000 (wrap).
- sel=3, rdo=0x80FF_7F01, loads:
  - LB addr_lo=2 → wb_wd=0xFFFF_FFFF.
  - LBU addr_lo=1 → 0x0000_007F.
  - LH addr_lo=2 → 0xFFFF_80FF.
  - LHU addr_lo=0 → 0x0000_7F01.
- Faults:
  - LW with addr_lo=1 → wb_wd=0, wb_we=0, fault=1 for one cycle, fault_sticky stays 1 until rst.
  - sel=5 → same response.
- stall=1 for 3 cycles after a capture → wb_* unchanged; then stall=1 and flush=1 together → wb_valid=0 next cycle.
- Forwarding:
  - wb_rd=7, wb_we=1, rs1=7, rs2=0 → fwd1=1, fwd2=0.
  - rd_in=0 with we_in=1 → wb_we=0, fwd1=fwd2=0 for any rs.
